// File: rtl/dds_pkg.sv
// Shared definitions for the DDS serial loader: FSM states, serial word layout
// and a helper that sizes the phase timer.
package dds_pkg;

    localparam int WORD_W = 40;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_HI,
        SER_WCLK,
        SER_FQUD,
        LOAD_LO,
        LOAD_HI,
        UPD_HI,
        UPD_LO
    } dds_state_e;

    // Bits needed to hold (max(a, b) - 1), never less than one.
    function automatic int timerWidth(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dds_half_period_timer.sv
// Loadable down-counter that times every phase of the loader. Loading N-1 on
// the edge that enters a phase makes the terminal count land on the phase's
// last cycle, so the phase lasts exactly N cycles.
module dds_half_period_timer #(
    parameter int W = 4
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] loadValue_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload on request, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadValue_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/dds_serial_loader.sv
// Drives the serial-mode pins of an AD985x-style DDS: a reset sequence that
// also switches the part into serial mode, and a 40-bit LSB-first word load
// followed by an FQ_UD strobe. All pin outputs come straight from flops.
module dds_serial_loader
    import dds_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        dds_rst,
    input  logic        dds_conf,
    input  logic [31:0] freq_word,
    input  logic [7:0]  phase_ctrl,
    output logic        dds_reset,
    output logic        dds_wclk,
    output logic        dds_fqud,
    output logic        dds_data,
    output logic        busy,
    output logic        done
);

    localparam int TW = timerWidth(DIV, RST_CYCLES);

    localparam logic [TW-1:0] DIV_LOAD = TW'(DIV - 1);
    localparam logic [TW-1:0] RST_LOAD = TW'(RST_CYCLES - 1);

    dds_state_e        state_q;
    logic              half_q;
    logic [CNT_W-1:0]  bitCnt_q;
    logic [WORD_W-1:0] shadow_q;
    logic              pending_q;

    logic              rstPrev_q;
    logic              confPrev_q;
    logic              armed_q;

    logic              reset_q;
    logic              wclk_q;
    logic              fqud_q;
    logic              data_q;
    logic              busy_q;
    logic              done_q;

    logic              rstEdge;
    logic              confEdge;
    logic              timerLoad;
    logic [TW-1:0]     timerValue;
    logic              timerTc;

    // Previous-value flops for edge detection; armed_q masks the first cycle
    // after reset so an input already held high is not taken as an edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rstPrev_q  <= 1'b0;
            confPrev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            rstPrev_q  <= dds_rst;
            confPrev_q <= dds_conf;
            armed_q    <= 1'b1;
        end
    end

    assign rstEdge  = armed_q & dds_rst  & ~rstPrev_q;
    assign confEdge = armed_q & dds_conf & ~confPrev_q;

    // Reload the phase timer whenever the FSM moves to a new phase.
    always_comb begin
        timerLoad  = 1'b0;
        timerValue = DIV_LOAD;
        if (rstEdge) begin
            timerLoad  = 1'b1;
            timerValue = RST_LOAD;
        end else if (state_q == IDLE) begin
            timerLoad = pending_q | confEdge;
        end else begin
            timerLoad = timerTc;
        end
    end

    dds_half_period_timer #(
        .W (TW)
    ) u_timer (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .load_i      (timerLoad),
        .loadValue_i (timerValue),
        .tc_o        (timerTc)
    );

    // Sequencer: states, shadow word, pending request and registered pins.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            half_q    <= 1'b0;
            bitCnt_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            reset_q   <= 1'b0;
            wclk_q    <= 1'b0;
            fqud_q    <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (confEdge && (state_q != IDLE || rstEdge)) begin
                pending_q <= 1'b1;
            end
            if (rstEdge) begin
                state_q  <= RST_HI;
                half_q   <= 1'b0;
                bitCnt_q <= '0;
                reset_q  <= 1'b1;
                wclk_q   <= 1'b0;
                fqud_q   <= 1'b0;
                data_q   <= 1'b0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pending_q || confEdge) begin
                            state_q   <= LOAD_LO;
                            pending_q <= 1'b0;
                            bitCnt_q  <= '0;
                            shadow_q  <= {phase_ctrl, freq_word};
                            data_q    <= freq_word[0];
                            wclk_q    <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                    RST_HI: begin
                        if (timerTc) begin
                            state_q <= SER_WCLK;
                            half_q  <= 1'b0;
                            reset_q <= 1'b0;
                            wclk_q  <= 1'b1;
                        end
                    end
                    SER_WCLK: begin
                        if (timerTc) begin
                            if (!half_q) begin
                                half_q <= 1'b1;
                                wclk_q <= 1'b0;
                            end else begin
                                state_q <= SER_FQUD;
                                half_q  <= 1'b0;
                                fqud_q  <= 1'b1;
                            end
                        end
                    end
                    SER_FQUD: begin
                        if (timerTc) begin
                            if (!half_q) begin
                                half_q <= 1'b1;
                                fqud_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                half_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    LOAD_LO: begin
                        if (timerTc) begin
                            state_q <= LOAD_HI;
                            wclk_q  <= 1'b1;
                        end
                    end
                    LOAD_HI: begin
                        if (timerTc) begin
                            wclk_q   <= 1'b0;
                            shadow_q <= shadow_q >> 1;
                            if (bitCnt_q == LAST_BIT) begin
                                state_q  <= UPD_HI;
                                bitCnt_q <= '0;
                                data_q   <= 1'b0;
                                fqud_q   <= 1'b1;
                            end else begin
                                state_q  <= LOAD_LO;
                                bitCnt_q <= bitCnt_q + 1'b1;
                                data_q   <= shadow_q[1];
                            end
                        end
                    end
                    UPD_HI: begin
                        if (timerTc) begin
                            state_q <= UPD_LO;
                            fqud_q  <= 1'b0;
                        end
                    end
                    UPD_LO: begin
                        if (timerTc) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dds_reset = reset_q;
    assign dds_wclk  = wclk_q;
    assign dds_fqud  = fqud_q;
    assign dds_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dds_serial_loader.sv
// Directed bench for dds_serial_loader with DIV=4, RST_CYCLES=8: reset
// sequence, word loads, shadow hold, abort, pending request and async reset.
module tb_dds_serial_loader;

    logic        clk_sys;
    logic        rst_n;
    logic        dds_rst;
    logic        dds_conf;
    logic [31:0] freq_word;
    logic [7:0]  phase_ctrl;
    logic        dds_reset;
    logic        dds_wclk;
    logic        dds_fqud;
    logic        dds_data;
    logic        busy;
    logic        done;

    int nCompared;
    int nMismatched;

    typedef struct {
        string      name;
        int         fromI;
        int         toI;
        logic [4:0] expected;
    } rstVec_t;

    typedef struct {
        string       name;
        logic [31:0] freq;
        logic [7:0]  phase;
        int          changeFall;
        logic [31:0] newFreq;
        logic [39:0] expWord;
    } loadVec_t;

    rstVec_t  rstVec  [7];
    loadVec_t loadVec [3];

    dds_serial_loader #(
        .DIV        (4),
        .RST_CYCLES (8)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .dds_rst    (dds_rst),
        .dds_conf   (dds_conf),
        .freq_word  (freq_word),
        .phase_ctrl (phase_ctrl),
        .dds_reset  (dds_reset),
        .dds_wclk   (dds_wclk),
        .dds_fqud   (dds_fqud),
        .dds_data   (dds_data),
        .busy       (busy),
        .done       (done)
    );

    // Free-running system clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Hard stop in case a sequence never finishes.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic [31:0] f, input logic [7:0] p);
        dds_rst    = r;
        dds_conf   = c;
        freq_word  = f;
        phase_ctrl = p;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Follows one load from LOAD_LO entry (i=1) up to its done pulse.
    task automatic watchLoad(input int changeFall, input logic [31:0] newFreq, input bit pulseConf,
                             output int doneAt, output logic [39:0] word, output int wPulses,
                             output int fPulses, output logic firstBusy);
        int   fallCnt;
        logic prevW;
        logic prevF;
        doneAt    = -1;
        word      = '0;
        wPulses   = 0;
        fPulses   = 0;
        fallCnt   = 0;
        prevW     = 1'b0;
        prevF     = 1'b0;
        firstBusy = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 1) firstBusy = busy;
            dds_conf = (pulseConf && (i == 50 || i == 100 || i == 150)) ? 1'b1 : 1'b0;
            if (dds_wclk && !prevW) begin
                if (wPulses < 40) word[wPulses] = dds_data;
                wPulses++;
            end
            if (!dds_wclk && prevW) begin
                fallCnt++;
                if (fallCnt == changeFall) freq_word = newFreq;
            end
            if (dds_fqud && !prevF) fPulses++;
            prevW = dds_wclk;
            prevF = dds_fqud;
            if (done) begin
                doneAt = i;
                break;
            end
        end
    endtask

    initial begin
        int          doneAt;
        int          wPulses;
        int          fPulses;
        int          fallCnt;
        int          doneCount;
        int          busyCount;
        logic [39:0] word;
        logic        firstBusy;
        logic        prevW;

        nCompared   = 0;
        nMismatched = 0;

        rstVec[0] = '{"rst_hi",       1,  8, 5'b10010};
        rstVec[1] = '{"ser_wclk_hi",  9, 12, 5'b01010};
        rstVec[2] = '{"ser_wclk_lo", 13, 16, 5'b00010};
        rstVec[3] = '{"ser_fqud_hi", 17, 20, 5'b00110};
        rstVec[4] = '{"ser_fqud_lo", 21, 24, 5'b00010};
        rstVec[5] = '{"rst_done",    25, 25, 5'b00001};
        rstVec[6] = '{"rst_after",   26, 27, 5'b00000};

        loadVec[0] = '{"load_one",    32'h0000_0001, 8'h00, 0, 32'h0,          40'h00_0000_0001};
        loadVec[1] = '{"load_shadow", 32'hA5A5_A5A5, 8'h00, 5, 32'h0000_0000, 40'h00_A5A5_A5A5};
        loadVec[2] = '{"load_mixed",  32'h1234_5678, 8'hC3, 0, 32'h0,          40'hC3_1234_5678};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 8'h0);
        repeat (3) tick();
        checkOutput("reset_outputs", {dds_reset, dds_wclk, dds_fqud, dds_data, busy, done}, 6'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("idle_outputs", {dds_reset, dds_wclk, dds_fqud, dds_data, busy, done}, 6'b0);

        $display("[TB] reset sequence");
        applyStimulus(1'b1, 1'b0, 32'h0, 8'h0);
        for (int s = 0; s < 7; s++) begin
            for (int i = rstVec[s].fromI; i <= rstVec[s].toI; i++) begin
                tick();
                if (i == 1) dds_rst = 1'b0;
                checkOutput(rstVec[s].name, {dds_reset, dds_wclk, dds_fqud, busy, done}, rstVec[s].expected);
            end
        end

        $display("[TB] word loads");
        for (int v = 0; v < 3; v++) begin
            applyStimulus(1'b0, 1'b1, loadVec[v].freq, loadVec[v].phase);
            watchLoad(loadVec[v].changeFall, loadVec[v].newFreq, 1'b0, doneAt, word, wPulses, fPulses, firstBusy);
            checkOutput({loadVec[v].name, "_word"},   word,      loadVec[v].expWord);
            checkOutput({loadVec[v].name, "_wclk"},   wPulses,   40);
            checkOutput({loadVec[v].name, "_fqud"},   fPulses,   1);
            checkOutput({loadVec[v].name, "_doneAt"}, doneAt,    329);
            checkOutput({loadVec[v].name, "_busy"},   firstBusy, 1'b1);
            repeat (3) tick();
        end

        $display("[TB] pending request");
        applyStimulus(1'b0, 1'b1, 32'h0000_00FF, 8'h81);
        watchLoad(0, 32'h0, 1'b1, doneAt, word, wPulses, fPulses, firstBusy);
        checkOutput("pend_first_doneAt", doneAt, 329);
        watchLoad(0, 32'h0, 1'b0, doneAt, word, wPulses, fPulses, firstBusy);
        checkOutput("pend_second_start",  firstBusy, 1'b1);
        checkOutput("pend_second_doneAt", doneAt,    329);
        checkOutput("pend_second_word",   word,      40'h81_0000_00FF);
        busyCount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busyCount++;
        end
        checkOutput("pend_no_third", busyCount, 0);

        $display("[TB] abort at bit 20");
        applyStimulus(1'b0, 1'b1, 32'h0010_0000, 8'h00);
        fallCnt = 0;
        prevW   = 1'b0;
        for (int i = 1; i <= 400 && fallCnt < 20; i++) begin
            tick();
            dds_conf = 1'b0;
            if (!dds_wclk && prevW) fallCnt++;
            prevW = dds_wclk;
        end
        checkOutput("abort_reached_bit20", fallCnt, 20);
        checkOutput("abort_pre_data", dds_data, 1'b1);
        dds_rst = 1'b1;
        tick();
        dds_rst = 1'b0;
        checkOutput("abort_outputs", {dds_reset, dds_wclk, dds_fqud, dds_data, busy, done}, 6'b100010);
        doneCount = 0;
        doneAt    = -1;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (done) begin
                doneCount++;
                if (doneAt < 0) doneAt = i;
            end
        end
        checkOutput("abort_done_count", doneCount, 1);
        checkOutput("abort_done_at",    doneAt,    25);

        $display("[TB] async reset mid-load");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        repeat (100) tick();
        checkOutput("async_pre_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_outputs", {dds_reset, dds_wclk, dds_fqud, dds_data, busy, done}, 6'b0);
        repeat (3) tick();
        #2;
        rst_n = 1'b1;
        busyCount = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) busyCount++;
        end
        checkOutput("async_no_load", busyCount, 0);
        dds_conf = 1'b0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
